// File: rtl/mm_sched_pkg.sv
// Shared widths, state encoding and address helper for the matrix-buffer scheduler.
// The optional watchdog is enabled by defining MM_SCHED_WDOG_EN.
package mm_sched_pkg;

   localparam int ADDR_W = 12;
   localparam int LEN_W  = 4;
   localparam int PASS_W = 4;
   localparam int GAP_W  = 4;
   localparam int WDOG_W = 8;

   localparam logic [ADDR_W-1:0] DEF_IRAM_STRIDE = 12'h100;
   localparam logic [ADDR_W-1:0] DEF_WRAM_STRIDE = 12'h100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } sched_state_e;

   // Byte addresses wrap modulo 4096 by construction of the 12-bit sum.
   function automatic logic [ADDR_W-1:0] addr_step(input logic [ADDR_W-1:0] addr,
                                                   input logic [ADDR_W-1:0] stride);
      return addr + stride;
   endfunction

endpackage

// File: rtl/mm_sched_end_track.sv
// Sticky end-of-pass flags for the IRAM and WRAM buffers, with the first-RUN-cycle mask.
// Flags only accumulate while run_i is high; anything seen outside RUN is discarded.
module mm_sched_end_track
   import mm_sched_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic run_i,
   input  logic clr_i,
   input  logic ibuf_end_i,
   input  logic wbuf_end_i,
   output logic both_done_o
);

   logic first_q;
   logic ibuf_flag_q, ibuf_flag_d;
   logic wbuf_flag_q, wbuf_flag_d;

   // The buffers derive end from a registered vld, so the first RUN cycle still shows the old pass.
   assign ibuf_flag_d = ibuf_flag_q | (ibuf_end_i & ~first_q);
   assign wbuf_flag_d = wbuf_flag_q | (wbuf_end_i & ~first_q);
   assign both_done_o = run_i & ibuf_flag_d & wbuf_flag_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         first_q     <= 1'b1;
         ibuf_flag_q <= 1'b0;
         wbuf_flag_q <= 1'b0;
      end else if (!run_i || clr_i) begin
         first_q     <= 1'b1;
         ibuf_flag_q <= 1'b0;
         wbuf_flag_q <= 1'b0;
      end else begin
         first_q     <= 1'b0;
         ibuf_flag_q <= ibuf_flag_d;
         wbuf_flag_q <= wbuf_flag_d;
      end
   end

endmodule

// File: rtl/mm_buff_sched.sv
// Sequences the IRAM/WRAM matrix buffers through 1..16 accumulate passes per matmul command.
// Define MM_SCHED_WDOG_EN to add the per-pass watchdog and the wdog_err output.
module mm_buff_sched
   import mm_sched_pkg::*;
#(
   parameter logic [ADDR_W-1:0] IRAM_STRIDE = DEF_IRAM_STRIDE,
   parameter logic [ADDR_W-1:0] WRAM_STRIDE = DEF_WRAM_STRIDE,
   parameter int unsigned       GAP_CYC     = 1
`ifdef MM_SCHED_WDOG_EN
  ,parameter int unsigned       WDOG_CYC    = 255
`endif
)(
   input  logic              clk,
   input  logic              rst,
   // Command handshake: a command transfers on a rising clk edge where cmd_vld and cmd_rdy are both high;
   // cmd_rdy is high only in IDLE and does not depend on cmd_vld, and cmd_vld is ignored otherwise.
   input  logic              cmd_vld,
   output logic              cmd_rdy,
   input  logic [ADDR_W-1:0] cmd_iram_addr,
   input  logic [ADDR_W-1:0] cmd_wram_addr,
   input  logic [LEN_W-1:0]  cmd_row_len,
   input  logic [LEN_W-1:0]  cmd_col_len,
   input  logic [PASS_W-1:0] cmd_pass_num,
   output logic              ibuf_ctrl_vld,
   output logic [ADDR_W-1:0] ibuf_ctrl_start_addr,
   output logic              wbuf_ctrl_vld,
   output logic [ADDR_W-1:0] wbuf_ctrl_start_addr,
   output logic [LEN_W-1:0]  buf_ctrl_row_len,
   output logic [LEN_W-1:0]  buf_ctrl_col_len,
   input  logic              ibuf_mxu_end,
   input  logic              wbuf_mxu_end,
   output logic              pass_first,
   output logic              busy,
   output sched_state_e      dbg_state,
   output logic              done
`ifdef MM_SCHED_WDOG_EN
  ,output logic              wdog_err
`endif
);

   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC - 1);

   sched_state_e      state_q;
   logic [ADDR_W-1:0] iram_addr_q, iram_addr_d;
   logic [ADDR_W-1:0] wram_addr_q, wram_addr_d;
   logic [LEN_W-1:0]  row_len_q, col_len_q;
   logic [PASS_W-1:0] pass_num_q, pass_cnt_q, pass_cnt_d;
   logic [GAP_W-1:0]  gap_cnt_q;
   logic              ctrl_vld_q, pass_first_q, busy_q, done_q, cmd_rdy_q;
   logic              run, both_done, wdog_trip, pass_end, last_pass;

   assign run         = (state_q == RUN);
   assign iram_addr_d = addr_step(iram_addr_q, IRAM_STRIDE);
   assign wram_addr_d = addr_step(wram_addr_q, WRAM_STRIDE);
   assign pass_cnt_d  = pass_cnt_q + PASS_W'(1);
   assign last_pass   = (pass_cnt_q == pass_num_q);
   assign pass_end    = both_done | wdog_trip;

   mm_sched_end_track u_end_track (
      .clk         (clk),
      .rst         (rst),
      .run_i       (run),
      .clr_i       (pass_end),
      .ibuf_end_i  (ibuf_mxu_end),
      .wbuf_end_i  (wbuf_mxu_end),
      .both_done_o (both_done)
   );

`ifdef MM_SCHED_WDOG_EN
   localparam logic [WDOG_W-1:0] WDOG_LIM = WDOG_W'(WDOG_CYC - 1);

   logic [WDOG_W-1:0] wdog_cnt_q;
   logic              wdog_err_q;

   // Counter holds the number of completed RUN cycles of the current pass; zero outside RUN.
   assign wdog_trip = run & ~both_done & (wdog_cnt_q == WDOG_LIM);
   assign wdog_err  = wdog_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wdog_cnt_q <= '0;
         wdog_err_q <= 1'b0;
      end else begin
         wdog_cnt_q <= run ? wdog_cnt_q + WDOG_W'(1) : '0;
         if (wdog_trip) wdog_err_q <= 1'b1;
      end
   end
`else
   assign wdog_trip = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         iram_addr_q  <= '0;
         wram_addr_q  <= '0;
         row_len_q    <= '0;
         col_len_q    <= '0;
         pass_num_q   <= '0;
         pass_cnt_q   <= '0;
         gap_cnt_q    <= '0;
         ctrl_vld_q   <= 1'b0;
         pass_first_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         cmd_rdy_q    <= 1'b1;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cmd_vld && cmd_rdy_q) begin
                  iram_addr_q  <= cmd_iram_addr;
                  wram_addr_q  <= cmd_wram_addr;
                  row_len_q    <= cmd_row_len;
                  col_len_q    <= cmd_col_len;
                  pass_num_q   <= cmd_pass_num;
                  pass_cnt_q   <= '0;
                  ctrl_vld_q   <= 1'b1;
                  pass_first_q <= 1'b1;
                  busy_q       <= 1'b1;
                  cmd_rdy_q    <= 1'b0;
                  state_q      <= RUN;
               end
            end
            RUN: begin
               if (pass_end) begin
                  ctrl_vld_q   <= 1'b0;
                  pass_first_q <= 1'b0;
                  if (last_pass || wdog_trip) begin
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     pass_cnt_q  <= pass_cnt_d;
                     iram_addr_q <= iram_addr_d;
                     wram_addr_q <= wram_addr_d;
                     gap_cnt_q   <= GAP_LOAD;
                     state_q     <= GAP;
                  end
               end
            end
            GAP: begin
               // Holding vld low gives each buffer a fresh rising edge for the next pass.
               if (gap_cnt_q == '0) begin
                  ctrl_vld_q <= 1'b1;
                  state_q    <= RUN;
               end else begin
                  gap_cnt_q <= gap_cnt_q - GAP_W'(1);
               end
            end
            DONE: begin
               busy_q    <= 1'b0;
               cmd_rdy_q <= 1'b1;
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cmd_rdy              = cmd_rdy_q;
   assign ibuf_ctrl_vld        = ctrl_vld_q;
   assign wbuf_ctrl_vld        = ctrl_vld_q;
   assign ibuf_ctrl_start_addr = iram_addr_q;
   assign wbuf_ctrl_start_addr = wram_addr_q;
   assign buf_ctrl_row_len     = row_len_q;
   assign buf_ctrl_col_len     = col_len_q;
   assign pass_first           = pass_first_q;
   assign busy                 = busy_q;
   assign done                 = done_q;
   assign dbg_state            = state_q;

endmodule

// File: tb/tb_mm_buff_sched.sv
// Randomised bench for mm_buff_sched: the bench plays both matrix buffers and predicts every cycle.
// Build with MM_SCHED_WDOG_EN to also exercise the watchdog.
module tb_mm_buff_sched;
   import mm_sched_pkg::*;

   localparam int GAP_N = 2;
   localparam int IST   = 256;
   localparam int WST   = 256;
`ifdef MM_SCHED_WDOG_EN
   localparam int WDOG_N = 20;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         cmd_vld = 1'b0;
   logic         cmd_rdy;
   logic [11:0]  cmd_iram_addr = '0, cmd_wram_addr = '0;
   logic [3:0]   cmd_row_len = '0, cmd_col_len = '0, cmd_pass_num = '0;
   logic         ibuf_ctrl_vld, wbuf_ctrl_vld;
   logic [11:0]  ibuf_ctrl_start_addr, wbuf_ctrl_start_addr;
   logic [3:0]   buf_ctrl_row_len, buf_ctrl_col_len;
   logic         ibuf_mxu_end = 1'b0, wbuf_mxu_end = 1'b0;
   logic         pass_first, busy, done;
   sched_state_e dbg_state;
`ifdef MM_SCHED_WDOG_EN
   logic         wdog_err;
`endif

   int checks = 0;
   int errors = 0;
   logic [23:0] exp_q[$];

   mm_buff_sched #(
      .GAP_CYC (GAP_N)
`ifdef MM_SCHED_WDOG_EN
     ,.WDOG_CYC(WDOG_N)
`endif
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .cmd_vld              (cmd_vld),
      .cmd_rdy              (cmd_rdy),
      .cmd_iram_addr        (cmd_iram_addr),
      .cmd_wram_addr        (cmd_wram_addr),
      .cmd_row_len          (cmd_row_len),
      .cmd_col_len          (cmd_col_len),
      .cmd_pass_num         (cmd_pass_num),
      .ibuf_ctrl_vld        (ibuf_ctrl_vld),
      .ibuf_ctrl_start_addr (ibuf_ctrl_start_addr),
      .wbuf_ctrl_vld        (wbuf_ctrl_vld),
      .wbuf_ctrl_start_addr (wbuf_ctrl_start_addr),
      .buf_ctrl_row_len     (buf_ctrl_row_len),
      .buf_ctrl_col_len     (buf_ctrl_col_len),
      .ibuf_mxu_end         (ibuf_mxu_end),
      .wbuf_mxu_end         (wbuf_mxu_end),
      .pass_first           (pass_first),
      .busy                 (busy),
      .dbg_state            (dbg_state),
      .done                 (done)
`ifdef MM_SCHED_WDOG_EN
     ,.wdog_err             (wdog_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference address for pass p: base plus p strides, modulo 4096.
   function automatic logic [11:0] model_addr(input logic [11:0] base, input int p, input int stride);
      return 12'((int'(base) + p * stride) % 4096);
   endfunction

   // mode 0: independent ends; 1: both ends in the same cycle; 2: ends glitch high in RUN cycle 1 and stay high through GAP.
   task automatic run_cmd(input string tag, input logic [11:0] ia, input logic [11:0] wa,
                          input logic [3:0] row, input logic [3:0] col, input logic [3:0] pn,
                          input int mode, input int ti0, input int tw0);
      int ti, tw, tend;
      logic [5:0]  obs, exp_ctl;
      logic [23:0] exp_a;
      exp_a = '0;
      for (int q = 0; q <= int'(pn); q++)
         exp_q.push_back({model_addr(ia, q, IST), model_addr(wa, q, WST)});
      obs = {ibuf_ctrl_vld, wbuf_ctrl_vld, pass_first, busy, done, cmd_rdy};
      checks++;
      if (obs !== 6'b000001) begin
         errors++;
         $display("FAIL %s idle_ctl got %b want %b", tag, obs, 6'b000001);
      end
      cmd_vld = 1'b1; cmd_iram_addr = ia; cmd_wram_addr = wa;
      cmd_row_len = row; cmd_col_len = col; cmd_pass_num = pn;
      step();
      cmd_iram_addr = 12'($urandom); cmd_wram_addr = 12'($urandom);
      cmd_row_len = 4'($urandom); cmd_col_len = 4'($urandom); cmd_pass_num = 4'($urandom);
      for (int p = 0; p <= int'(pn); p++) begin
         if (p == 0 && ti0 > 0) begin
            ti = ti0; tw = tw0;
         end else if (mode == 1) begin
            ti = $urandom_range(2, 10); tw = ti;
         end else if (mode == 2) begin
            ti = $urandom_range(3, 10); tw = $urandom_range(3, 10);
         end else begin
            ti = $urandom_range(2, 10); tw = $urandom_range(2, 10);
         end
         tend = (ti > tw) ? ti : tw;
         for (int k = 1; k <= tend; k++) begin
            ibuf_mxu_end = (k >= ti) || (mode == 2 && k == 1);
            wbuf_mxu_end = (k >= tw) || (mode == 2 && k == 1);
            cmd_vld = 1'($urandom_range(0, 1));
            exp_ctl = {1'b1, 1'b1, (p == 0), 1'b1, 1'b0, 1'b0};
            obs = {ibuf_ctrl_vld, wbuf_ctrl_vld, pass_first, busy, done, cmd_rdy};
            checks++;
            if (obs !== exp_ctl) begin
               errors++;
               $display("FAIL %s run_ctl pass %0d cyc %0d got %b want %b", tag, p, k, obs, exp_ctl);
            end
            if (k == 1) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL %s addr_queue pass %0d got empty want entry", tag, p);
               end else begin
                  exp_a = exp_q.pop_front();
               end
            end
            checks++;
            if ({ibuf_ctrl_start_addr, wbuf_ctrl_start_addr} !== exp_a) begin
               errors++;
               $display("FAIL %s addr pass %0d cyc %0d got %h want %h", tag, p, k,
                        {ibuf_ctrl_start_addr, wbuf_ctrl_start_addr}, exp_a);
            end
            checks++;
            if ({buf_ctrl_row_len, buf_ctrl_col_len} !== {row, col}) begin
               errors++;
               $display("FAIL %s lens got %h want %h", tag, {buf_ctrl_row_len, buf_ctrl_col_len}, {row, col});
            end
            step();
         end
         if (p < int'(pn)) begin
            for (int g = 0; g < GAP_N; g++) begin
               ibuf_mxu_end = (mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
               wbuf_mxu_end = (mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
               cmd_vld = 1'($urandom_range(0, 1));
               obs = {ibuf_ctrl_vld, wbuf_ctrl_vld, pass_first, busy, done, cmd_rdy};
               checks++;
               if (obs !== 6'b000100) begin
                  errors++;
                  $display("FAIL %s gap_ctl pass %0d cyc %0d got %b want %b", tag, p, g, obs, 6'b000100);
               end
               step();
            end
         end else begin
            ibuf_mxu_end = 1'b0; wbuf_mxu_end = 1'b0; cmd_vld = 1'b0;
            obs = {ibuf_ctrl_vld, wbuf_ctrl_vld, pass_first, busy, done, cmd_rdy};
            checks++;
            if (obs !== 6'b000110) begin
               errors++;
               $display("FAIL %s done_ctl got %b want %b", tag, obs, 6'b000110);
            end
            step();
         end
      end
      obs = {ibuf_ctrl_vld, wbuf_ctrl_vld, pass_first, busy, done, cmd_rdy};
      checks++;
      if (obs !== 6'b000001 || {buf_ctrl_row_len, buf_ctrl_col_len} !== {row, col}) begin
         errors++;
         $display("FAIL %s post_ctl got %b/%h want %b/%h", tag, obs,
                  {buf_ctrl_row_len, buf_ctrl_col_len}, 6'b000001, {row, col});
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; cmd_vld = 1'b1;
      step(); step();
      cmd_vld = 1'b0; rst = 1'b0;
      checks++;
      if ({ibuf_ctrl_vld, wbuf_ctrl_vld, pass_first, busy, done, cmd_rdy} !== 6'b000001) begin
         errors++;
         $display("FAIL reset_ctl got %b want %b",
                  {ibuf_ctrl_vld, wbuf_ctrl_vld, pass_first, busy, done, cmd_rdy}, 6'b000001);
      end
      checks++;
      if ({ibuf_ctrl_start_addr, wbuf_ctrl_start_addr, buf_ctrl_row_len, buf_ctrl_col_len} !== 32'h0) begin
         errors++;
         $display("FAIL reset_data got %h want 0",
                  {ibuf_ctrl_start_addr, wbuf_ctrl_start_addr, buf_ctrl_row_len, buf_ctrl_col_len});
      end
      checks++;
      if (dbg_state !== IDLE) begin
         errors++;
         $display("FAIL reset_state got %0d want %0d", dbg_state, IDLE);
      end
`ifdef MM_SCHED_WDOG_EN
      checks++;
      if (wdog_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_wdog got %b want 0", wdog_err);
      end
`endif
      step();
   endtask

   task automatic test_single_pass();
      run_cmd("single", 12'h000, 12'h040, 4'd3, 4'd3, 4'd0, 0, 7, 9);
   endtask

   task automatic test_three_pass();
      run_cmd("three", 12'h010, 12'h020, 4'd5, 4'd7, 4'd2, 0, 0, 0);
   endtask

   task automatic test_simultaneous();
      run_cmd("simul", 12'h300, 12'h480, 4'd1, 4'd2, 4'd2, 1, 0, 0);
   endtask

   task automatic test_first_cycle_mask();
      run_cmd("mask", 12'h0A0, 12'h0B0, 4'd9, 4'd4, 4'd3, 2, 0, 0);
   endtask

   task automatic test_wrap();
      run_cmd("wrap", 12'hF00, 12'hFC0, 4'd15, 4'd15, 4'd1, 0, 0, 0);
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 6; n++)
         run_cmd("b2b", 12'($urandom), 12'($urandom), 4'($urandom), 4'($urandom),
                 4'($urandom_range(0, 4)), $urandom_range(0, 2), 0, 0);
   endtask

   task automatic test_rst_mid_run();
      cmd_vld = 1'b1; cmd_iram_addr = 12'h123; cmd_wram_addr = 12'h456;
      cmd_row_len = 4'd6; cmd_col_len = 4'd2; cmd_pass_num = 4'd3;
      step();
      cmd_vld = 1'b0;
      step(); step();
      checks++;
      if ({ibuf_ctrl_vld, busy} !== 2'b11) begin
         errors++;
         $display("FAIL rstmid_pre got %b want %b", {ibuf_ctrl_vld, busy}, 2'b11);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if ({ibuf_ctrl_vld, wbuf_ctrl_vld, pass_first, busy, done, cmd_rdy} !== 6'b000001 || dbg_state !== IDLE) begin
         errors++;
         $display("FAIL rstmid_ctl got %b/%0d want %b/%0d",
                  {ibuf_ctrl_vld, wbuf_ctrl_vld, pass_first, busy, done, cmd_rdy}, dbg_state, 6'b000001, IDLE);
      end
      for (int k = 0; k < 4; k++) begin
         ibuf_mxu_end = 1'b1; wbuf_mxu_end = 1'b1;
         step();
         checks++;
         if ({done, busy, cmd_rdy} !== 3'b001) begin
            errors++;
            $display("FAIL rstmid_quiet cyc %0d got %b want %b", k, {done, busy, cmd_rdy}, 3'b001);
         end
      end
      ibuf_mxu_end = 1'b0; wbuf_mxu_end = 1'b0;
   endtask

`ifdef MM_SCHED_WDOG_EN
   task automatic test_wdog();
      cmd_vld = 1'b1; cmd_iram_addr = 12'h200; cmd_wram_addr = 12'h300;
      cmd_row_len = 4'd1; cmd_col_len = 4'd1; cmd_pass_num = 4'd2;
      step();
      cmd_vld = 1'b0;
      for (int k = 1; k <= WDOG_N; k++) begin
         ibuf_mxu_end = (k >= 3); wbuf_mxu_end = 1'b0;
         checks++;
         if ({ibuf_ctrl_vld, done, wdog_err} !== 3'b100) begin
            errors++;
            $display("FAIL wdog_run cyc %0d got %b want %b", k, {ibuf_ctrl_vld, done, wdog_err}, 3'b100);
         end
         step();
      end
      ibuf_mxu_end = 1'b0;
      checks++;
      if ({ibuf_ctrl_vld, done, wdog_err} !== 3'b011) begin
         errors++;
         $display("FAIL wdog_trip got %b want %b", {ibuf_ctrl_vld, done, wdog_err}, 3'b011);
      end
      step();
      checks++;
      if ({cmd_rdy, done, wdog_err} !== 3'b101) begin
         errors++;
         $display("FAIL wdog_sticky got %b want %b", {cmd_rdy, done, wdog_err}, 3'b101);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (wdog_err !== 1'b0) begin
         errors++;
         $display("FAIL wdog_clear got %b want 0", wdog_err);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_pass();
      test_three_pass();
      test_simultaneous();
      test_first_cycle_mask();
      test_wrap();
      test_back_to_back();
      test_rst_mid_run();
`ifdef MM_SCHED_WDOG_EN
      test_wdog();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
